led_seq_checker: RTL and testbench

LED_SEQ_CHECKER -- requirements
Module: led_seq_checker

---
 rtl/led_seq_checker_if.sv | 23 ++
 rtl/led_seq_checker.sv | 138 +++++++++++++
 tb/tb_led_seq_checker.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/led_seq_checker_if.sv
// led_seq_checker_if -- bundles the sample strobe, the observed LED bus and
// the checker's status outputs.
//   tick    : one-cycle sample strobe (master -> slave)
//   led     : observed 8-bit running-light bus (master -> slave)
//   locked  : checker is tracking a valid rotation (slave -> master)
//   fault   : checker lost lock and waits for a one-hot sample (slave -> master)
//   err     : one-cycle pulse per detected sequence error (slave -> master)
//   pos     : index of the set bit in the last accepted sample (slave -> master)
//   err_cnt : saturating error count, or 0 when the counter is not built (slave -> master)
interface led_seq_checker_if;
  logic       tick;
  logic [7:0] led;
  logic       locked;
  logic       fault;
  logic       err;
  logic [2:0] pos;
  logic [7:0] err_cnt;

  modport master (output tick, led,
                  input  locked, fault, err, pos, err_cnt);
  modport slave  (input  tick, led,
                  output locked, fault, err, pos, err_cnt);
endinterface

// File: rtl/led_seq_checker.sv
// led_seq_checker -- watches a one-hot running-light bus and checks that it
// rotates left by one position on every tick.
//   CLK : system clock, rising edge
//   rs  : synchronous active-high reset; wins over a simultaneous tick
//   bus : led_seq_checker_if.slave (tick/led in; locked/fault/err/pos/err_cnt out)
// Parameter LOCK_N (1..15): consecutive correct steps needed to lock.
// Macro LEDCHK_ERRCNT_EN: when defined, builds the saturating 8-bit error
// counter; otherwise err_cnt is tied to 0.
//
// state  | meaning
// IDLE   | waiting for the first one-hot sample
// ACQ    | counting consecutive correct rotations toward LOCK_N
// LOCKED | tracking; any deviation (including a stall) is an error
// FAULT  | lost lock; waiting for a one-hot sample to re-acquire
module led_seq_checker #(
  parameter int LOCK_N = 4
) (
  input  logic              CLK,
  input  logic              rs,
  led_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  state_t     state, state_nx;
  logic [7:0] prev, prev_nx;
  logic [3:0] good_cnt, good_nx;
  logic       err_nx;
  logic [2:0] pos_nx;
  logic       locked_q, fault_q, err_q;
  logic [2:0] pos_q;
  logic       one_hot;
  logic       rot_ok;

  // x & (x-1) clears the lowest set bit, so it is zero only for 0 or 1 bits set
  assign one_hot = (bus.led != 8'h00) && ((bus.led & (bus.led - 8'd1)) == 8'h00);
  assign rot_ok  = (bus.led == {prev[6:0], prev[7]});

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    good_nx  = good_cnt;
    err_nx   = 1'b0;
    if (bus.tick) begin
      case (state)
        IDLE: begin
          if (one_hot) begin
            prev_nx  = bus.led;
            good_nx  = 4'd0;
            state_nx = ACQ;
          end
        end
        ACQ: begin
          if (!one_hot) begin
            state_nx = IDLE;
          end else begin
            prev_nx = bus.led;
            if (rot_ok) begin
              good_nx = good_cnt + 4'd1;
              if (good_nx == LOCK_V) state_nx = LOCKED;
            end else begin
              good_nx = 4'd0;
            end
          end
        end
        LOCKED: begin
          // prev is one-hot here, so rot_ok implies led is one-hot too
          if (rot_ok) begin
            prev_nx = bus.led;
          end else begin
            state_nx = FAULT;
            err_nx   = 1'b1;
          end
        end
        FAULT: begin
          if (one_hot) begin
            prev_nx  = bus.led;
            good_nx  = 4'd0;
            state_nx = ACQ;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // pos follows prev, so it naturally holds whenever prev is not updated
  always_comb begin
    pos_nx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (prev_nx[i]) pos_nx = 3'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (rs) begin
      state    <= IDLE;
      prev     <= 8'h00;
      good_cnt <= 4'd0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= 3'd0;
    end else begin
      state    <= state_nx;
      prev     <= prev_nx;
      good_cnt <= good_nx;
      locked_q <= (state_nx == LOCKED);
      fault_q  <= (state_nx == FAULT);
      err_q    <= err_nx;
      pos_q    <= pos_nx;
    end
  end

  assign bus.locked = locked_q;
  assign bus.fault  = fault_q;
  assign bus.err    = err_q;
  assign bus.pos    = pos_q;

`ifdef LEDCHK_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK) begin
    if (rs) begin
      err_cnt_q <= 8'h00;
    end else if (err_nx && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_led_seq_checker.sv
// tb_led_seq_checker -- self-checking bench for led_seq_checker (LOCK_N=4).
// Each tick pushes the expected outputs onto a scoreboard queue; after the
// clock edge the entry is popped and compared. Every tick is followed by a
// tick=0 cycle that checks outputs hold and err drops back to 0.
module tb_led_seq_checker;

  typedef struct packed {
    logic       locked;
    logic       fault;
    logic       err;
    logic [2:0] pos;
    logic [7:0] cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic rs  = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   errs   = 0;
  exp_t sb[$];
  logic [7:0] cur;

  led_seq_checker_if bus ();

  led_seq_checker #(.LOCK_N(4)) dut (
    .CLK (CLK),
    .rs  (rs),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_cnt();
`ifdef LEDCHK_ERRCNT_EN
    return (errs > 255) ? 8'hFF : 8'(errs);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [2:0] idx(input logic [7:0] x);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (x[i]) r = 3'(i);
    return r;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".locked"}, {7'd0, bus.locked}, {7'd0, e.locked});
    chk({tag, ".fault"},  {7'd0, bus.fault},  {7'd0, e.fault});
    chk({tag, ".err"},    {7'd0, bus.err},    {7'd0, e.err});
    chk({tag, ".pos"},    {5'd0, bus.pos},    {5'd0, e.pos});
    chk({tag, ".err_cnt"}, bus.err_cnt, e.cnt);
  endtask

  // one stimulus cycle plus one quiet cycle
  task automatic tk(input string tag, input logic t, input logic r, input logic [7:0] l,
                    input logic el, input logic ef, input logic ee, input logic [2:0] ep);
    exp_t e;
    @(negedge CLK);
    bus.tick = t;
    bus.led  = l;
    rs       = r;
    if (r) errs = 0;
    else if (ee) errs++;
    e = '{locked: el, fault: ef, err: ee, pos: ep, cnt: exp_cnt()};
    sb.push_back(e);
    @(posedge CLK);
    #1;
    compare(tag);
    @(negedge CLK);
    bus.tick = 1'b0;
    bus.led  = 8'hA5;
    rs       = 1'b0;
    e.err    = 1'b0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    compare({tag, "_hold"});
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.led  = 8'h00;

    tk("reset0", 1'b0, 1'b1, 8'h00, 0, 0, 0, 3'd0);
    tk("reset1", 1'b1, 1'b1, 8'h01, 0, 0, 0, 3'd0);

    // acquisition and lock
    tk("acq01", 1'b1, 1'b0, 8'h01, 0, 0, 0, 3'd0);
    tk("acq02", 1'b1, 1'b0, 8'h02, 0, 0, 0, 3'd1);
    tk("acq04", 1'b1, 1'b0, 8'h04, 0, 0, 0, 3'd2);
    tk("acq08", 1'b1, 1'b0, 8'h08, 0, 0, 0, 3'd3);
    tk("lock10", 1'b1, 1'b0, 8'h10, 1, 0, 0, 3'd4);
    tk("lk20", 1'b1, 1'b0, 8'h20, 1, 0, 0, 3'd5);
    tk("lk40", 1'b1, 1'b0, 8'h40, 1, 0, 0, 3'd6);
    tk("lk80", 1'b1, 1'b0, 8'h80, 1, 0, 0, 3'd7);
    tk("wrap01", 1'b1, 1'b0, 8'h01, 1, 0, 0, 3'd0);
    tk("lk02", 1'b1, 1'b0, 8'h02, 1, 0, 0, 3'd1);
    tk("lk04", 1'b1, 1'b0, 8'h04, 1, 0, 0, 3'd2);

    // stall while locked
    tk("stall04", 1'b1, 1'b0, 8'h04, 0, 1, 1, 3'd2);
    tk("flt03", 1'b1, 1'b0, 8'h03, 0, 1, 0, 3'd2);
    tk("flt00", 1'b1, 1'b0, 8'h00, 0, 1, 0, 3'd2);
    tk("reacq10", 1'b1, 1'b0, 8'h10, 0, 0, 0, 3'd4);
    tk("reacq20", 1'b1, 1'b0, 8'h20, 0, 0, 0, 3'd5);
    tk("reacq40", 1'b1, 1'b0, 8'h40, 0, 0, 0, 3'd6);
    tk("reacq80", 1'b1, 1'b0, 8'h80, 0, 0, 0, 3'd7);
    tk("relock01", 1'b1, 1'b0, 8'h01, 1, 0, 0, 3'd0);

    // multi-bit value while locked, then mismatches in ACQ/IDLE raise no err
    tk("bad55", 1'b1, 1'b0, 8'h55, 0, 1, 1, 3'd0);
    tk("f2a01", 1'b1, 1'b0, 8'h01, 0, 0, 0, 3'd0);
    tk("acqskip04", 1'b1, 1'b0, 8'h04, 0, 0, 0, 3'd2);
    tk("acqinv00", 1'b1, 1'b0, 8'h00, 0, 0, 0, 3'd2);
    tk("idle03", 1'b1, 1'b0, 8'h03, 0, 0, 0, 3'd2);
    tk("i2a08", 1'b1, 1'b0, 8'h08, 0, 0, 0, 3'd3);
    tk("a10", 1'b1, 1'b0, 8'h10, 0, 0, 0, 3'd4);
    tk("a20", 1'b1, 1'b0, 8'h20, 0, 0, 0, 3'd5);
    tk("a40", 1'b1, 1'b0, 8'h40, 0, 0, 0, 3'd6);
    tk("lock80", 1'b1, 1'b0, 8'h80, 1, 0, 0, 3'd7);
    tk("notick", 1'b0, 1'b0, 8'hFF, 1, 0, 0, 3'd7);

    // repeated lock/fault cycles drive the error counter into saturation
    cur = 8'h80;
    for (int k = 0; k < 300; k++) begin
      tk("sat_stall", 1'b1, 1'b0, cur, 0, 1, 1, idx(cur));
      tk("sat_acq", 1'b1, 1'b0, cur, 0, 0, 0, idx(cur));
      for (int j = 0; j < 4; j++) begin
        cur = rotl(cur);
        tk("sat_step", 1'b1, 1'b0, cur, (j == 3), 0, 0, idx(cur));
      end
    end
`ifdef LEDCHK_ERRCNT_EN
    chk("sat_final", bus.err_cnt, 8'hFF);
`else
    chk("sat_final", bus.err_cnt, 8'h00);
`endif

    // reset beats a simultaneous tick while locked
    tk("rs_tick55", 1'b1, 1'b1, 8'h55, 0, 0, 0, 3'd0);
    tk("post_rs02", 1'b1, 1'b0, 8'h02, 0, 0, 0, 3'd1);
    tk("post_rs_stall", 1'b1, 1'b0, 8'h02, 0, 0, 0, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
